// File: rtl/lc9_state_sequencer.sv
// LogicCore9 state register and next-state logic: produces the 4-bit control code Q (0..13).
// Optional Q==7 wait timeout is enabled by defining LC9_SEQ_TIMEOUT_EN.
module lc9_state_sequencer #(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             abort,
  input  logic             ack,
  output logic [3:0]       Q,
  output logic             in_rdy,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_PRE1   = 4'd1,
    S_PRE2   = 4'd2,
    S_PRE3   = 4'd3,
    S_PRE4   = 4'd4,
    S_PRE5   = 4'd5,
    S_PRE6   = 4'd6,
    S_OPND2  = 4'd7,
    S_POST8  = 4'd8,
    S_POST9  = 4'd9,
    S_POST10 = 4'd10,
    S_POST11 = 4'd11,
    S_POST12 = 4'd12,
    S_DONE   = 4'd13,
    S_BAD14  = 4'd14,
    S_BAD15  = 4'd15
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]       q_q, q_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;
  logic             start_acc;

`ifdef LC9_SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;

  // Counter idles at zero outside Q==7, so entering Q==7 always starts a fresh count.
  always_comb begin
    wait_d  = '0;
    timeout = 1'b0;
    if ((q_q == S_OPND2) && !in_valid) begin
      if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
        timeout = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    q_d   = q_q;
    err_d = 1'b0;
    if (q_q > S_DONE) begin
      q_d   = S_IDLE;
      err_d = 1'b1;
    end else if (abort && (q_q != S_IDLE)) begin
      q_d = S_IDLE;
    end else if (timeout) begin
      q_d   = S_IDLE;
      err_d = 1'b1;
    end else if ((q_q == S_DONE) && ack) begin
      q_d = S_IDLE;
    end else if (!stall) begin
      case (q_q)
        S_IDLE:  if (start) q_d = S_PRE1;
        S_OPND2: if (in_valid) q_d = S_POST8;
        S_DONE:  q_d = S_DONE;
        default: q_d = q_q + 4'd1;
      endcase
    end

    busy_d    = (q_d != S_IDLE);
    start_acc = (q_q == S_IDLE) && (q_d == S_PRE1);

    // The accepting cycle is the first cycle of the run, so a fresh run starts at 1.
    cnt_d = cnt_q;
    if (start_acc) begin
      cnt_d = CNT_W'(1);
    end else if ((q_q != S_IDLE) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= S_IDLE;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      busy_q <= busy_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Q       = q_q;
  assign in_rdy  = (q_q == S_IDLE) || (q_q == S_OPND2);
  assign done    = (q_q == S_DONE);
  assign busy    = busy_q;
  assign err     = err_q;
  assign cyc_cnt = cnt_q;

endmodule

// File: tb/tb_lc9_state_sequencer.sv
// Self-checking bench for lc9_state_sequencer: behavioural model with per-cycle compare
// plus directed scenarios with hand-computed latencies and counts.
module tb_lc9_state_sequencer;

  localparam int CNT_W       = 8;
  localparam int TIMEOUT_CYC = 64;
  localparam int CNT_CAP     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             stall = 1'b0;
  logic             abort = 1'b0;
  logic             ack = 1'b0;
  logic [3:0]       Q;
  logic             in_rdy;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] cyc_cnt;

  int checks = 0;
  int failures = 0;

  lc9_state_sequencer #(
    .CNT_W(CNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .stall(stall),
    .abort(abort),
    .ack(ack),
    .Q(Q),
    .in_rdy(in_rdy),
    .busy(busy),
    .done(done),
    .err(err),
    .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and reports a mismatch on a single line.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Drives all control inputs at once (called just after a falling edge).
  task automatic applyStimulus(input logic s, input logic v, input logic st,
                               input logic ab, input logic ak);
    start    = s;
    in_valid = v;
    stall    = st;
    abort    = ab;
    ack      = ak;
  endtask

  // Advances falling edges until Q reaches target, bounded by budget.
  task automatic stepTo(input int target, input int budget, output int n);
    n = 0;
    while ((int'(Q) != target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_q", int'(Q), target);
  endtask

  // Behavioural model: state code as a plain integer following the sequencing rules.
  int m_q = 0;
  int m_cnt = 0;
  bit m_busy = 1'b0;
  bit m_err = 1'b0;
  bit inject = 1'b0;
  int m_cur;
  int m_nq;
  bit m_ne;
  bit m_to;
`ifdef LC9_SEQ_TIMEOUT_EN
  int m_wait = 0;
  int m_nw;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q    <= 0;
      m_cnt  <= 0;
      m_busy <= 1'b0;
      m_err  <= 1'b0;
`ifdef LC9_SEQ_TIMEOUT_EN
      m_wait <= 0;
`endif
    end else begin
      m_cur = inject ? 15 : m_q;
      m_ne  = 1'b0;
      m_to  = 1'b0;
`ifdef LC9_SEQ_TIMEOUT_EN
      m_nw = ((m_cur == 7) && !in_valid) ? m_wait + 1 : 0;
      m_to = (m_nw >= TIMEOUT_CYC);
      m_wait <= m_to ? 0 : m_nw;
`endif
      if (m_cur >= 14) begin
        m_nq = 0;
        m_ne = 1'b1;
      end else if (abort && (m_cur != 0)) m_nq = 0;
      else if (m_to) begin
        m_nq = 0;
        m_ne = 1'b1;
      end else if ((m_cur == 13) && ack) m_nq = 0;
      else if (stall) m_nq = m_cur;
      else if (m_cur == 0) m_nq = start ? 1 : 0;
      else if (m_cur == 7) m_nq = in_valid ? 8 : 7;
      else if (m_cur == 13) m_nq = 13;
      else m_nq = m_cur + 1;

      m_q    <= m_nq;
      m_busy <= (m_nq != 0);
      m_err  <= m_ne;
      if ((m_cur == 0) && (m_nq != 0)) m_cnt <= 1;
      else if (m_cur != 0) m_cnt <= (m_cnt >= CNT_CAP) ? CNT_CAP : m_cnt + 1;
    end
  end

  // Per-cycle compare of every output against the model, 2 time units after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      checkOutput("cmp_q", int'(Q), m_q);
      checkOutput("cmp_busy", int'(busy), int'(m_busy));
      checkOutput("cmp_done", int'(done), int'(m_q == 13));
      checkOutput("cmp_in_rdy", int'(in_rdy), int'((m_q == 0) || (m_q == 7)));
      checkOutput("cmp_err", int'(err), int'(m_err));
      checkOutput("cmp_cnt", int'(cyc_cnt), m_cnt);
    end
  end

  // Hard stop in case a scenario wedges.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int   lat;
  int   n;
  int   stallLeft;
  int   delayLeft;
  logic s;
  logic v;

  // Directed scenarios with literal expectations.
  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_q", int'(Q), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_cnt", int'(cyc_cnt), 0);
    checkOutput("rst_in_rdy", int'(in_rdy), 1);
    checkOutput("rst_done", int'(done), 0);
    rst = 1'b0;

    @(negedge clk);
    applyStimulus(1, 1, 1, 0, 0);
    @(negedge clk);
    checkOutput("stall_blocks_start", int'(Q), 0);

    $display("[TB] minimum-latency run");
    applyStimulus(1, 1, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 0);
    lat = 1;
    checkOutput("first_q", int'(Q), 1);
    checkOutput("first_busy", int'(busy), 1);
    while (!done && (lat < 40)) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency_min", lat, 13);
    checkOutput("cnt_at_done_min", int'(cyc_cnt), 13);
    repeat (2) @(negedge clk);
    checkOutput("done_holds", int'(Q), 13);
    applyStimulus(0, 0, 1, 0, 1);
    @(negedge clk);
    checkOutput("ack_with_stall_q", int'(Q), 0);
    checkOutput("ack_busy", int'(busy), 0);
    checkOutput("cnt_after_ack", int'(cyc_cnt), 16);
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("cnt_holds_idle", int'(cyc_cnt), 16);

    $display("[TB] stall and delayed operand run");
    applyStimulus(1, 0, 0, 0, 0);
    lat = 0;
    stallLeft = 3;
    delayLeft = 5;
    while (!done && (lat < 60)) begin
      @(negedge clk);
      lat++;
      s = 1'b0;
      v = 1'b1;
      if ((Q == 4'd4) && (stallLeft > 0)) begin
        s = 1'b1;
        stallLeft--;
      end
      if ((Q == 4'd7) && (delayLeft > 0)) begin
        v = 1'b0;
        delayLeft--;
      end
      applyStimulus(0, v, s, 0, 0);
    end
    checkOutput("latency_stalled", lat, 21);
    checkOutput("cnt_at_done_stalled", int'(cyc_cnt), 21);
    applyStimulus(0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("ack_q", int'(Q), 0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] abort run");
    @(negedge clk);
    applyStimulus(1, 1, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 0);
    stepTo(11, 20, n);
    applyStimulus(0, 1, 0, 1, 0);
    @(negedge clk);
    checkOutput("abort_q", int'(Q), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_err", int'(err), 0);
    @(negedge clk);
    checkOutput("abort_idle_noeffect", int'(Q), 0);
    applyStimulus(1, 1, 0, 1, 0);
    @(negedge clk);
    checkOutput("start_with_abort_idle", int'(Q), 1);
    checkOutput("restart_cnt", int'(cyc_cnt), 1);
    applyStimulus(0, 1, 0, 0, 0);
    stepTo(13, 20, n);
    applyStimulus(0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("ack2_q", int'(Q), 0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] reset mid-run");
    @(negedge clk);
    applyStimulus(1, 1, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 0);
    stepTo(9, 20, n);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_q", int'(Q), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    checkOutput("async_rst_err", int'(err), 0);
    checkOutput("async_rst_cnt", int'(cyc_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] illegal code recovery");
    @(negedge clk);
    inject = 1'b1;
    force dut.q_q = 4'd15;
    #1 release dut.q_q;
    @(posedge clk);
    #1 inject = 1'b0;
    @(negedge clk);
    checkOutput("illegal_q", int'(Q), 0);
    checkOutput("illegal_err", int'(err), 1);
    checkOutput("illegal_busy", int'(busy), 0);
    @(negedge clk);
    checkOutput("illegal_err_pulse", int'(err), 0);

`ifdef LC9_SEQ_TIMEOUT_EN
    $display("[TB] operand timeout");
    applyStimulus(1, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    stepTo(7, 20, n);
    stepTo(0, 200, n);
    checkOutput("timeout_cycles", n, TIMEOUT_CYC);
    checkOutput("timeout_err", int'(err), 1);
    @(negedge clk);
    checkOutput("timeout_err_pulse", int'(err), 0);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
